// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-rate controller slice.
// Preset table is only referenced when UART_BAUD_PRESET_EN is defined.
package uart_pkg;

    localparam int unsigned FREQ_W   = 12;
    localparam int unsigned LIMIT_W  = 16;
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned DRAIN_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_APPLY  = 2'd2,
        ST_SETTLE = 2'd3
    } baud_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0]  freq;
        logic [LIMIT_W-1:0] limit;
    } baud_cfg_t;

    // Generator settings for common rates with a 50 MHz clock
    localparam baud_cfg_t PRESET_9600   = '{freq: FREQ_W'(96),   limit: LIMIT_W'(31154)};
    localparam baud_cfg_t PRESET_19200  = '{freq: FREQ_W'(192),  limit: LIMIT_W'(31058)};
    localparam baud_cfg_t PRESET_57600  = '{freq: FREQ_W'(576),  limit: LIMIT_W'(30674)};
    localparam baud_cfg_t PRESET_115200 = '{freq: FREQ_W'(1152), limit: LIMIT_W'(30098)};

    function automatic baud_cfg_t preset_lookup(input logic [1:0] idx);
        case (idx)
            2'd0:    return PRESET_9600;
            2'd1:    return PRESET_19200;
            2'd2:    return PRESET_57600;
            default: return PRESET_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_check.sv
// Combinational validity check of a requested baud_freq/baud_limit pair.
// With UART_BAUD_PRESET_EN, cfg_limit==0 selects a preset by cfg_freq[1:0].
module uart_baud_check
    import uart_pkg::*;
(
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [LIMIT_W-1:0] cfg_limit,
    output logic [FREQ_W-1:0]  freq_c,
    output logic [LIMIT_W-1:0] limit_c,
    output logic               valid_c
);

    baud_cfg_t cfg;

    always_comb begin
        cfg = '{freq: cfg_freq, limit: cfg_limit};
`ifdef UART_BAUD_PRESET_EN
        if (cfg_limit == '0) begin
            cfg = preset_lookup(cfg_freq[1:0]);
        end
`endif
        freq_c  = cfg.freq;
        limit_c = cfg.limit;
        // limit >= freq keeps ce_16 at or below half the clock rate
        valid_c = (cfg.freq != '0) && (cfg.limit >= LIMIT_W'(cfg.freq));
    end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Run-time baud switch controller: validate, drain UART, apply atomically, settle.
// Optional preset table selected by UART_BAUD_PRESET_EN (see uart_baud_check).
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter logic [FREQ_W-1:0]  RST_FREQ      = FREQ_W'(1152),
    parameter logic [LIMIT_W-1:0] RST_LIMIT     = LIMIT_W'(30098),
    parameter int unsigned        SETTLE_TICKS  = 32,
    parameter int unsigned        DRAIN_TIMEOUT = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [LIMIT_W-1:0] cfg_limit,
    input  logic               uart_idle,
    input  logic               ce_16,
    output logic [FREQ_W-1:0]  baud_freq,
    output logic [LIMIT_W-1:0] baud_limit,
    output logic               uart_hold,
    output logic               busy,
    output logic               cfg_done,
    output logic               cfg_err
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);

    baud_state_e         state, state_nx;
    baud_cfg_t           pend, pend_nx;
    baud_cfg_t           baud, baud_nx;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nx;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_nx;
    logic                done_nx, err_nx;

    logic [FREQ_W-1:0]   chk_freq_c;
    logic [LIMIT_W-1:0]  chk_limit_c;
    logic                chk_valid_c;

    uart_baud_check u_check (
        .cfg_freq (cfg_freq),
        .cfg_limit(cfg_limit),
        .freq_c   (chk_freq_c),
        .limit_c  (chk_limit_c),
        .valid_c  (chk_valid_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pend       <= '0;
            baud       <= '{freq: RST_FREQ, limit: RST_LIMIT};
            settle_cnt <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            uart_hold  <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            baud       <= baud_nx;
            settle_cnt <= settle_cnt_nx;
            drain_cnt  <= drain_cnt_nx;
            busy       <= (state_nx != ST_IDLE);
            uart_hold  <= (state_nx != ST_IDLE);
            cfg_done   <= done_nx;
            cfg_err    <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pend_nx       = pend;
        baud_nx       = baud;
        settle_cnt_nx = settle_cnt;
        drain_cnt_nx  = drain_cnt;
        done_nx       = 1'b0;
        err_nx        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cfg_wr) begin
                    if (chk_valid_c) begin
                        pend_nx      = '{freq: chk_freq_c, limit: chk_limit_c};
                        drain_cnt_nx = '0;
                        state_nx     = ST_DRAIN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_nx = drain_cnt + DRAIN_W'(1);
                if (uart_idle) begin
                    state_nx = ST_APPLY;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                end
            end
            ST_APPLY: begin
                // Both generator inputs change on the same edge
                baud_nx       = pend;
                settle_cnt_nx = '0;
                state_nx      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (ce_16) begin
                    settle_cnt_nx = settle_cnt + SETTLE_W'(1);
                    if (settle_cnt + SETTLE_W'(1) == SETTLE_LAST) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Requests during a switch are dropped and flagged
        if (cfg_wr && (state != ST_IDLE)) begin
            err_nx = 1'b1;
        end
    end

    assign baud_freq  = baud.freq;
    assign baud_limit = baud.limit;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: expected completions/errors are queued
// at request time and checked when cfg_done/cfg_err pulse.
module tb_uart_baud_ctrl;
    import uart_pkg::*;

    localparam int unsigned SETTLE_TICKS  = 4;
    localparam int unsigned DRAIN_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [11:0] cfg_freq = '0;
    logic [15:0] cfg_limit = '0;
    logic        uart_idle = 1'b1;
    logic        ce_16 = 1'b0;
    logic [11:0] baud_freq;
    logic [15:0] baud_limit;
    logic        uart_hold, busy, cfg_done, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] cur_f = 12'd1152;
    logic [15:0] cur_l = 16'd30098;

    baud_cfg_t done_q[$];
    baud_cfg_t err_q[$];
    baud_cfg_t mon_e;

    uart_baud_ctrl #(
        .RST_FREQ     (12'd1152),
        .RST_LIMIT    (16'd30098),
        .SETTLE_TICKS (SETTLE_TICKS),
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_freq  (cfg_freq),
        .cfg_limit (cfg_limit),
        .uart_idle (uart_idle),
        .ce_16     (ce_16),
        .baud_freq (baud_freq),
        .baud_limit(baud_limit),
        .uart_hold (uart_hold),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Scoreboard side: pop the expected generator values on every pulse
    always @(negedge clock) begin
        if (reset === 1'b0 && cfg_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = done_q.pop_front();
                check("done_freq", 32'(baud_freq), 32'(mon_e.freq));
                check("done_limit", 32'(baud_limit), 32'(mon_e.limit));
            end
        end
        if (reset === 1'b0 && cfg_err === 1'b1) begin
            if (err_q.size() == 0) begin
                check("err_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = err_q.pop_front();
                check("err_freq", 32'(baud_freq), 32'(mon_e.freq));
                check("err_limit", 32'(baud_limit), 32'(mon_e.limit));
            end
        end
    end

    task automatic issue(input logic [11:0] f, input logic [15:0] l);
        cfg_freq  = f;
        cfg_limit = l;
        cfg_wr    = 1'b1;
        step();
        cfg_wr    = 1'b0;
    endtask

    // Pulses ce_16 SETTLE_TICKS times with gaps; ends at negedge of the done cycle
    task automatic pulse_ce();
        for (int i = 0; i < int'(SETTLE_TICKS); i++) begin
            ce_16 = 1'b1;
            step();
            ce_16 = 1'b0;
            sample();
            if (i < int'(SETTLE_TICKS) - 1) begin
                check("hold_in_settle", 32'(uart_hold), 32'd1);
                check("no_early_done", 32'(cfg_done), 32'd0);
                step();
            end
        end
        check("done_pulse", 32'(cfg_done), 32'd1);
        check("hold_released", 32'(uart_hold), 32'd0);
        check("busy_released", 32'(busy), 32'd0);
    endtask

    task automatic run_switch(input logic [11:0] f, input logic [15:0] l,
                              input logic [11:0] ef, input logic [15:0] el);
        done_q.push_back('{freq: ef, limit: el});
        issue(f, l);
        sample();
        check("busy_c1", 32'(busy), 32'd1);
        check("hold_c1", 32'(uart_hold), 32'd1);
        check("freq_c1_old", 32'(baud_freq), 32'(cur_f));
        step();
        ce_16 = 1'b1;
        sample();
        check("freq_apply_old", 32'(baud_freq), 32'(cur_f));
        check("limit_apply_old", 32'(baud_limit), 32'(cur_l));
        step();
        ce_16 = 1'b0;
        sample();
        check("freq_c3_new", 32'(baud_freq), 32'(ef));
        check("limit_c3_new", 32'(baud_limit), 32'(el));
        cur_f = ef;
        cur_l = el;
        pulse_ce();
    endtask

    task automatic bad_req(input logic [11:0] f, input logic [15:0] l);
        err_q.push_back('{freq: cur_f, limit: cur_l});
        issue(f, l);
        sample();
        check("bad_err_pulse", 32'(cfg_err), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_hold", 32'(uart_hold), 32'd0);
        check("bad_freq_kept", 32'(baud_freq), 32'(cur_f));
        step();
        sample();
        check("bad_err_once", 32'(cfg_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        step();
        step();
        step();
        reset = 1'b0;
        sample();
        check("rst_freq", 32'(baud_freq), 32'd1152);
        check("rst_limit", 32'(baud_limit), 32'd30098);
        check("rst_hold", 32'(uart_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        step();

        run_switch(12'd576, 16'd30674, 12'd576, 16'd30674);
        // Request in the done cycle must be accepted
        run_switch(12'd1152, 16'd30098, 12'd1152, 16'd30098);
        step();
        sample();
        check("done_one_cycle", 32'(cfg_done), 32'd0);

        bad_req(12'd0, 16'd100);
        bad_req(12'd200, 16'd100);

        run_switch(12'd300, 16'd300, 12'd300, 16'd300);
        step();

        // Drain timeout with UART never idle
        uart_idle = 1'b0;
        err_q.push_back('{freq: cur_f, limit: cur_l});
        issue(12'd96, 16'd31154);
        sample();
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_hold", 32'(uart_hold), 32'd1);
        lat = 1;
        while (cfg_err !== 1'b1 && lat < 40) begin
            step();
            sample();
            lat++;
        end
        check("drain_timeout_lat", 32'(lat), 32'(DRAIN_TIMEOUT + 1));
        check("drain_busy_clr", 32'(busy), 32'd0);
        check("drain_hold_clr", 32'(uart_hold), 32'd0);
        check("drain_freq_kept", 32'(baud_freq), 32'(cur_f));
        uart_idle = 1'b1;
        step();

`ifdef UART_BAUD_PRESET_EN
        run_switch(12'd1, 16'd0, 12'd192, 16'd31058);
        step();
`else
        bad_req(12'd1, 16'd0);
`endif

        // Second request during SETTLE is rejected; first switch completes
        done_q.push_back('{freq: 12'd192, limit: 16'd31058});
        issue(12'd192, 16'd31058);
        step();
        step();
        sample();
        check("coll_applied", 32'(baud_freq), 32'd192);
        cur_f = 12'd192;
        cur_l = 16'd31058;
        err_q.push_back('{freq: cur_f, limit: cur_l});
        issue(12'd96, 16'd31154);
        sample();
        check("coll_err", 32'(cfg_err), 32'd1);
        check("coll_busy", 32'(busy), 32'd1);
        step();
        pulse_ce();
        check("coll_keep_freq", 32'(baud_freq), 32'd192);
        check("coll_keep_limit", 32'(baud_limit), 32'd31058);
        step();

        // Reset mid-SETTLE returns the generator to its reset pair at once
        issue(12'd576, 16'd30674);
        step();
        step();
        sample();
        check("mid_applied", 32'(baud_freq), 32'd576);
        step();
        ce_16 = 1'b1;
        step();
        ce_16 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_freq", 32'(baud_freq), 32'd1152);
        check("async_rst_limit", 32'(baud_limit), 32'd30098);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hold", 32'(uart_hold), 32'd0);
        step();
        reset = 1'b0;
        step();
        sample();
        check("post_rst_idle", 32'(busy), 32'd0);

        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("err_q_empty", 32'(err_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
- Run-time controller for the UART baud rate generator.
- Accepts a new baud_freq/baud_limit pair from the register interface and range-checks it.
- Waits until the UART transmitter and receiver are idle, then drives the new pair onto the generator inputs atomically.
- Holds off new transfers for a settling interval counted in ce_16 ticks, then releases the UART. Sits between the CPU register bank and the baud generator/UART core.

Parameters:
- RST_FREQ, 1152, baud_freq driven after reset (115200 Bd at 50 MHz).
- RST_LIMIT, 30098, baud_limit driven after reset (115200 Bd at 50 MHz).
- SETTLE_TICKS, 32, ce_16 pulses to wait after a switch before releasing the hold (range 1..255).
- DRAIN_TIMEOUT, 1000000, clock cycles to wait for UART idle before aborting (range 1..2^24-1).

Ports:
- clock  in  1  global clock
- reset  in  1  asynchronous reset, active-high
- cfg_wr  in  1  single-cycle request to apply cfg_freq/cfg_limit
- cfg_freq  in  12  requested baud_freq
- cfg_limit  in  16  requested baud_limit
- uart_idle  in  1  high when both the tx and rx shift paths are idle
- ce_16  in  1  baud-x16 enable from the generator
- baud_freq  out  12  to the generator
- baud_limit  out  16  to the generator
- uart_hold  out  1  high: the UART must not start a new tx frame
- busy  out  1  high while a switch is in progress
- cfg_done  out  1  one-cycle pulse when a switch completes
- cfg_err  out  1  one-cycle pulse on rejected or aborted request

Behaviour:
- Reset values:
  - baud_freq=RST_FREQ, baud_limit=RST_LIMIT.
  - uart_hold=0, busy=0, cfg_done=0, cfg_err=0.
  - State IDLE; all counters 0.
- States: IDLE, DRAIN, APPLY, SETTLE.
- IDLE, on cfg_wr:
  - Validate the request: cfg_freq != 0 and cfg_limit >= cfg_freq. The second condition guarantees ce_16 <= clock/2.
  - Invalid request: cfg_err=1 on the next cycle; stay in IDLE; outputs unchanged.
  - Valid request: latch cfg_freq/cfg_limit into pending registers; go to DRAIN. busy=1 and uart_hold=1 from the next cycle.
- DRAIN:
  - A drain counter increments every cycle.
  - If uart_idle=1, go to APPLY.
  - If the counter reaches DRAIN_TIMEOUT-1 without idle, go to IDLE. Pulse cfg_err; clear busy and uart_hold; the outputs keep their old values.
  - uart_hold prevents new tx frames. rx activity extends DRAIN naturally.
- APPLY (exactly one cycle):
  - baud_freq and baud_limit load from the pending registers in the same clock edge, so they never change independently.
  - Clear the settle counter; go to SETTLE.
- SETTLE:
  - Count ce_16 pulses.
  - When the count reaches SETTLE_TICKS, go to IDLE: pulse cfg_done, clear busy and uart_hold.
- Latency for a valid request with uart_idle already high:
  - cfg_wr at cycle 0; DRAIN at cycle 1; APPLY at cycle 2.
  - New baud values visible from cycle 3.
  - cfg_done asserts on the edge after the SETTLE_TICKS-th ce_16 pulse.
- cfg_wr while busy=1: ignored and not queued; cfg_err pulses for one cycle; the switch in progress is unaffected.
- cfg_wr in the same cycle that cfg_done or cfg_err pulses: the FSM is already back in IDLE that cycle, so the request is accepted normally.
- ce_16 arriving in the same cycle as APPLY is not counted.
- Counter widths: settle counter 8 bits, drain counter 24 bits; neither wraps before its terminal compare.
- Reset asserted mid-operation: immediate return to reset values, including baud_freq/baud_limit back to RST_FREQ/RST_LIMIT; pending request lost.
- uart_idle and ce_16 are synchronous to clock; the block does no CDC.

Optional Feature:
- Macro: UART_BAUD_PRESET_EN.
- Defined:
  - cfg_freq[1:0] is a preset index when cfg_limit == 16'h0000.
  - Index maps to a constant table: 0=9600 (freq 96, limit 31154), 1=19200 (192, 31058), 2=57600 (576, 30674), 3=115200 (1152, 30098), all for 50 MHz.
  - The selected pair replaces cfg_freq/cfg_limit before validation.
- Not defined: cfg_limit == 0 fails the validity rule and yields cfg_err. No table logic is synthesised.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (2-bit).
  - Baud preset table constants.
  - Widths FREQ_W=12, LIMIT_W=16.
- One natural sub-module: uart_baud_check, a combinational validity check plus preset mapping, reusable by the register bank for readback status.
- The FSM and counters stay in uart_baud_ctrl.

Test Plan:
- Reset released -> baud_freq=1152, baud_limit=30098, uart_hold=0, busy=0.
- cfg_wr with freq=576, limit=30674, uart_idle=1, SETTLE_TICKS=4 -> outputs update at cycle 3; cfg_done exactly one cycle after the 4th ce_16; uart_hold high from cycle 1 until then.
- cfg_wr with freq=0, limit=100 -> cfg_err pulse at cycle 1; outputs unchanged. Second case, freq=200 and limit=100 -> same result.
- Valid cfg_wr with uart_idle=0 held and DRAIN_TIMEOUT=16 -> cfg_err at the end of DRAIN; outputs unchanged; busy and uart_hold deasserted.
- Second cfg_wr during SETTLE -> cfg_err pulse; first switch completes with the first values. Reset asserted mid-SETTLE -> outputs return to 1152/30098 asynchronously.
- UART_BAUD_PRESET_EN defined, cfg_freq=1, cfg_limit=0 -> baud_freq=192, baud_limit=31058 after the switch. Macro undefined, same stimulus -> cfg_err.
